girl_sprite_fetch: RTL and testbench

Upstream pixel stage for the Watergirl character sprite. For each VGA pixel it decides whether the pixel lies inside the character's bounding box, computes the sprite ROM address (animation frame, horizontal mirroring), issues the read, and delivers a 4-bit palette index plus a hit flag, aligned two clocks after the pixel coordinate. The output index drives the character palette lookup directly; the hit flag tells the colour mapper to use the sprite colour instead of the background.

---
 rtl/girl_sprite_fetch.sv | 94 +++++++++
 tb/tb_girl_sprite_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/girl_sprite_fetch.sv
// Watergirl sprite pixel fetch: bounding-box test, ROM address generation with
// walk-cycle frame and mirroring, and a 2-clock registered palette-index/hit output.
module girl_sprite_fetch #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 6,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              facing_left,
    input  logic              moving,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        palette_index,
    output logic              pix_hit,
    output logic [1:0]        anim_frame
);

    localparam int XB     = $clog2(SPR_W);
    localparam int YB     = $clog2(SPR_H);
    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [1:0]        LAST_FRAME = 2'(NUM_FRAMES - 1);
    localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [10:0]       BOX_W      = 11'(SPR_W);
    localparam logic [10:0]       BOX_H      = 11'(SPR_H);

    logic [9:0]        lx;
    logic [9:0]        ly;
    logic              lfacing;
    logic [TICK_W-1:0] tick;
    logic              in_box_d1;

    logic              in_box;
    logic [XB-1:0]     dx;
    logic [XB-1:0]     col;
    logic [YB-1:0]     dy;
    logic [ADDR_W-1:0] addr_next;

    // Upper bounds are 11 bits wide so a box near the right/bottom edge
    // cannot wrap around and reappear at column/row 0.
    always_comb begin
        in_box = ({1'b0, DrawX} >= {1'b0, lx}) && ({1'b0, DrawX} < ({1'b0, lx} + BOX_W)) &&
                 ({1'b0, DrawY} >= {1'b0, ly}) && ({1'b0, DrawY} < ({1'b0, ly} + BOX_H));
        dx        = XB'(DrawX) - XB'(lx);
        dy        = YB'(DrawY) - YB'(ly);
        col       = lfacing ? ~dx : dx;
        addr_next = ADDR_W'({anim_frame, dy, col});
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lx            <= '0;
            ly            <= '0;
            lfacing       <= 1'b0;
            tick          <= '0;
            anim_frame    <= '0;
            rom_addr      <= '0;
            in_box_d1     <= 1'b0;
            palette_index <= '0;
            pix_hit       <= 1'b0;
        end else begin
            if (frame_start) begin
                lx      <= pos_x;
                ly      <= pos_y;
                lfacing <= facing_left;
                if (!moving) begin
                    anim_frame <= '0;
                    tick       <= '0;
                end else if (tick == LAST_TICK) begin
                    tick       <= '0;
                    anim_frame <= (anim_frame == LAST_FRAME) ? 2'd0 : anim_frame + 2'd1;
                end else begin
                    tick <= tick + 1'b1;
                end
            end
            // Stage 1: address for the pixel sampled this cycle.
            rom_addr  <= in_box ? addr_next : '0;
            in_box_d1 <= in_box;
            // Stage 2: ROM data for the pixel sampled one cycle earlier.
            palette_index <= in_box_d1 ? rom_q : 4'd0;
            pix_hit       <= in_box_d1 && (rom_q != 4'(TRANSP_IDX));
        end
    end

endmodule

// File: tb/tb_girl_sprite_fetch.sv
// Directed bench for girl_sprite_fetch: driver tasks push expected address and
// pixel results; a negedge monitor pops and compares as each pipeline slot emerges.
module tb_girl_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        facing_left = 1'b0;
    logic        moving = 1'b0;
    logic [9:0]  DrawX = 10'd1023;
    logic [9:0]  DrawY = 10'd1023;
    logic [11:0] rom_addr;
    logic [3:0]  rom_q = '0;
    logic [3:0]  palette_index;
    logic        pix_hit;
    logic [1:0]  anim_frame;

    int tests  = 0;
    int failed = 0;

    logic [11:0] exp_addr_q[$];
    logic [4:0]  exp_pix_q[$];   // {palette_index, pix_hit}
    logic [3:0]  pending_q = '0;
    logic        drive_valid = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;

    girl_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left), .moving(moving),
        .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_q(rom_q),
        .palette_index(palette_index), .pix_hit(pix_hit), .anim_frame(anim_frame)
    );

    // clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // slot tags follow the DUT pipeline
    always @(posedge Clk) begin
        v1 <= drive_valid;
        v2 <= v1;
    end

    // scoreboard monitor
    always @(negedge Clk) begin
        if (v1) begin
            if (exp_addr_q.size() == 0) check("addr_q_underflow", 1, 0);
            else check("rom_addr", int'(rom_addr), int'(exp_addr_q.pop_front()));
        end
        if (v2) begin
            if (exp_pix_q.size() == 0) check("pix_q_underflow", 1, 0);
            else begin
                logic [4:0] e;
                e = exp_pix_q.pop_front();
                check("palette_index", int'(palette_index), int'(e[4:1]));
                check("pix_hit", int'(pix_hit), int'(e[0]));
            end
        end
    end

    // driver tasks: each occupies one clock starting at a negedge
    task automatic pix(input int x, input int y, input int q,
                       input int e_addr, input int e_idx, input int e_hit);
        @(negedge Clk);
        Reset       = 1'b0;
        frame_start = 1'b0;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        rom_q       = pending_q;
        pending_q   = 4'(q);
        drive_valid = 1'b1;
        exp_addr_q.push_back(12'(e_addr));
        exp_pix_q.push_back({4'(e_idx), 1'(e_hit)});
    endtask

    task automatic idle();
        @(negedge Clk);
        Reset       = 1'b0;
        frame_start = 1'b0;
        DrawX       = 10'd1023;
        DrawY       = 10'd1023;
        rom_q       = pending_q;
        pending_q   = '0;
        drive_valid = 1'b0;
    endtask

    task automatic do_frame(input int px, input int py, input bit f, input bit m);
        @(negedge Clk);
        Reset       = 1'b0;
        frame_start = 1'b1;
        pos_x       = 10'(px);
        pos_y       = 10'(py);
        facing_left = f;
        moving      = m;
        DrawX       = 10'd1023;
        DrawY       = 10'd1023;
        rom_q       = pending_q;
        pending_q   = '0;
        drive_valid = 1'b0;
    endtask

    task automatic moving_frames(input int n);
        for (int i = 0; i < n; i++) begin
            do_frame(100, 200, 1'b0, 1'b1);
            idle();
        end
    endtask

    // Reset asserted while an in-box pixel is presented: that slot and the
    // one ahead of it must both come out flushed.
    task automatic rst_cyc();
        @(negedge Clk);
        Reset       = 1'b1;
        frame_start = 1'b0;
        DrawX       = 10'd100;
        DrawY       = 10'd200;
        rom_q       = pending_q;
        pending_q   = 4'd5;
        drive_valid = 1'b1;
        exp_addr_q.push_back(12'd0);
        exp_pix_q.push_back(5'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge Clk);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_palette_index", int'(palette_index), 0);
        check("reset_pix_hit", int'(pix_hit), 0);
        check("reset_anim_frame", int'(anim_frame), 0);

        // basic hit, bounds, transparency
        do_frame(100, 200, 1'b0, 1'b0);
        pix(100, 200, 5, 0, 5, 1);
        pix(131, 231, 7, 1023, 7, 1);
        pix(99, 200, 9, 0, 0, 0);
        pix(132, 200, 9, 0, 0, 0);
        pix(100, 232, 9, 0, 0, 0);
        pix(110, 205, 0, 170, 0, 0);
        pos_x = 10'd300;             // mid-frame change, no frame_start
        pix(100, 200, 3, 0, 3, 1);

        // mirrored
        do_frame(100, 200, 1'b1, 1'b0);
        pix(100, 200, 2, 31, 2, 1);
        pix(131, 201, 4, 32, 4, 1);
        pix(120, 210, 6, 331, 6, 1);

        // walk animation
        moving_frames(6);
        check("anim_after_6", int'(anim_frame), 1);
        pix(100, 200, 1, 1024, 1, 1);
        moving_frames(6);
        check("anim_after_12", int'(anim_frame), 2);
        pix(105, 203, 8, 2149, 8, 1);
        moving_frames(6);
        check("anim_after_18", int'(anim_frame), 3);
        moving_frames(6);
        check("anim_after_24", int'(anim_frame), 0);
        moving_frames(12);
        check("anim_before_stop", int'(anim_frame), 2);
        do_frame(100, 200, 1'b0, 1'b0);
        idle();
        check("anim_after_stop", int'(anim_frame), 0);

        // screen-edge clip
        do_frame(620, 460, 1'b0, 1'b0);
        pix(639, 479, 11, 627, 11, 1);
        pix(0, 460, 5, 0, 0, 0);
        pix(11, 479, 5, 0, 0, 0);
        pix(619, 470, 5, 0, 0, 0);

        // reset mid-line
        moving_frames(6);
        check("anim_before_reset", int'(anim_frame), 1);
        pix(100, 200, 5, 1024, 0, 0);
        rst_cyc();
        pix(100, 200, 5, 0, 0, 0);
        pix(101, 201, 6, 0, 0, 0);
        idle();
        check("anim_after_reset", int'(anim_frame), 0);
        repeat (3) idle();

        check("addr_q_drained", exp_addr_q.size(), 0);
        check("pix_q_drained", exp_pix_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
